// File: rtl/long_divider_sequential_if.sv
// long_divider_sequential_if: request/result bus of the sequential divider.
// Define SIGNED_DIVISION_EN to add the signed_i operand-mode line.
interface long_divider_sequential_if #(parameter int DATA_WIDTH = 32);
    logic [DATA_WIDTH-1:0] dividend_i;
    logic [DATA_WIDTH-1:0] divisor_i;
    logic                  data_valid_i;
`ifdef SIGNED_DIVISION_EN
    logic                  signed_i;
`endif
    logic [DATA_WIDTH-1:0] quotient_o;
    logic [DATA_WIDTH-1:0] remainder_o;
    logic                  data_valid_o;
    logic                  divide_by_zero_o;
    logic                  idle_o;

    modport master (
`ifdef SIGNED_DIVISION_EN
        output signed_i,
`endif
        output dividend_i, divisor_i, data_valid_i,
        input  quotient_o, remainder_o, data_valid_o, divide_by_zero_o, idle_o
    );

    modport slave (
`ifdef SIGNED_DIVISION_EN
        input  signed_i,
`endif
        input  dividend_i, divisor_i, data_valid_i,
        output quotient_o, remainder_o, data_valid_o, divide_by_zero_o, idle_o
    );
endinterface

// File: rtl/long_divider_sequential.sv
// long_divider_sequential: restoring divider, one quotient bit per clock.
// Define SIGNED_DIVISION_EN for two's-complement operands selected by signed_i.
module long_divider_sequential #(
    parameter int DATA_WIDTH = 32
) (
    input logic clk_i,
    input logic rst_n_i,
    long_divider_sequential_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    state_t        state, state_next;
    logic [W-1:0]  q, b, q_next, a_mag, b_mag, q_fix, r_fix;
    logic [W:0]    r, r_shift, r_next;
    logic [CW-1:0] cnt;
    logic [W-1:0]  quotient, remainder;
    logic          dbz, load, zero, ge, last;

`ifdef SIGNED_DIVISION_EN
    logic neg_q, neg_r, sa, sb;
    assign sa    = bus.signed_i & bus.dividend_i[W-1];
    assign sb    = bus.signed_i & bus.divisor_i[W-1];
    assign a_mag = sa ? -bus.dividend_i : bus.dividend_i;
    assign b_mag = sb ? -bus.divisor_i : bus.divisor_i;
    // Sign correction folds into the final iteration so latency matches unsigned
    assign q_fix = neg_q ? -q_next : q_next;
    assign r_fix = neg_r ? -r_next[W-1:0] : r_next[W-1:0];
`else
    assign a_mag = bus.dividend_i;
    assign b_mag = bus.divisor_i;
    assign q_fix = q_next;
    assign r_fix = r_next[W-1:0];
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        load       = state == IDLE && bus.data_valid_i;
        zero       = bus.divisor_i == '0;
        last       = state == DIVIDE && cnt == '0;
        state_next = state == IDLE   ? (load ? (zero ? DONE : DIVIDE) : IDLE) :
                     state == DIVIDE ? (last ? DONE : DIVIDE) : IDLE;
        r_shift    = {r[W-1:0], q[W-1]};
        ge         = r_shift >= {1'b0, b};
        r_next     = ge ? r_shift - {1'b0, b} : r_shift;
        q_next     = {q[W-2:0], ge};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q         <= '0;
            b         <= '0;
            r         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
`ifdef SIGNED_DIVISION_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else if (load) begin
            q   <= a_mag;
            b   <= b_mag;
            r   <= '0;
            cnt <= CW'(W - 1);
`ifdef SIGNED_DIVISION_EN
            neg_q <= sa ^ sb;
            neg_r <= sa;
`endif
            if (zero) begin
                quotient  <= '1;
                remainder <= bus.dividend_i;
                dbz       <= 1'b1;
            end
        end else if (state == DIVIDE) begin
            q   <= q_next;
            r   <= r_next;
            cnt <= cnt - 1'b1;
            if (last) begin
                quotient  <= q_fix;
                remainder <= r_fix;
                dbz       <= 1'b0;
            end
        end
    end

    assign bus.quotient_o       = quotient;
    assign bus.remainder_o      = remainder;
    assign bus.divide_by_zero_o = dbz;
    assign bus.data_valid_o     = state == DONE;
    assign bus.idle_o           = state == IDLE;
endmodule
